// File: rtl/line_mem_arbiter_if.sv
// Bus bundle for the line memory arbiter: I-cache fill port, D-cache fill and
// write-back ports, and the single backing-memory port.
interface line_mem_arbiter_if #(
    parameter int LINE_W  = 128,
    parameter int LADDR_W = 10
);
    logic               Ic_mem_req;
    logic [LADDR_W-1:0] Ic_mem_addr;
    logic [LINE_W-1:0]  F_mem_inst;
    logic               F_mem_valid;

    logic               Dc_mem_req;
    logic [LADDR_W-1:0] Dc_mem_addr;
    logic [LINE_W-1:0]  MEM_data_line;
    logic               MEM_mem_valid;

    logic               Dc_wb_we;
    logic [LADDR_W-1:0] Dc_wb_addr;
    logic [LINE_W-1:0]  Dc_wb_wline;
    logic               Dc_wb_done;

    logic               Mem_req;
    logic               Mem_we;
    logic [LADDR_W-1:0] Mem_addr;
    logic [LINE_W-1:0]  Mem_wline;
    logic [LINE_W-1:0]  Mem_rline;
    logic               Mem_done;

    modport slave (
        input  Ic_mem_req, Ic_mem_addr,
        input  Dc_mem_req, Dc_mem_addr,
        input  Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        input  Mem_rline, Mem_done,
        output F_mem_inst, F_mem_valid,
        output MEM_data_line, MEM_mem_valid,
        output Dc_wb_done,
        output Mem_req, Mem_we, Mem_addr, Mem_wline
    );

    modport master (
        output Ic_mem_req, Ic_mem_addr,
        output Dc_mem_req, Dc_mem_addr,
        output Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        output Mem_rline, Mem_done,
        input  F_mem_inst, F_mem_valid,
        input  MEM_data_line, MEM_mem_valid,
        input  Dc_wb_done,
        input  Mem_req, Mem_we, Mem_addr, Mem_wline
    );
endinterface

// File: rtl/line_mem_arbiter.sv
// Serialises I fetch, D read and D write-back onto one single-ported line memory.
// Priority WB > DRD > I, with an I-side starvation override after STARVE_LIMIT D grants.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | pick one pending requester, latch its command
//  BUSY    | Mem_req held with a stable command until Mem_done
//  RESP    | one-cycle response pulse to the granted requester
module line_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    line_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] G_I   = 2'd0;
    localparam logic [1:0] G_DRD = 2'd1;
    localparam logic [1:0] G_WB  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    gnt;
    logic [1:0]    gnt_sel;
    logic          any_req;
    logic [SW-1:0] d_streak;

    // The starvation override only lifts I above the D side; WB vs DRD order is untouched.
    always_comb begin
        any_req = 1'b1;
        gnt_sel = G_I;
        if (bus.Ic_mem_req && (d_streak == STREAK_MAX)) begin
            gnt_sel = G_I;
        end else if (bus.Dc_wb_we) begin
            gnt_sel = G_WB;
        end else if (bus.Dc_mem_req) begin
            gnt_sel = G_DRD;
        end else if (bus.Ic_mem_req) begin
            gnt_sel = G_I;
        end else begin
            any_req = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            gnt               <= G_I;
            d_streak          <= '0;
            bus.Mem_req       <= 1'b0;
            bus.Mem_we        <= 1'b0;
            bus.Mem_addr      <= '0;
            bus.Mem_wline     <= '0;
            bus.F_mem_inst    <= '0;
            bus.F_mem_valid   <= 1'b0;
            bus.MEM_data_line <= '0;
            bus.MEM_mem_valid <= 1'b0;
            bus.Dc_wb_done    <= 1'b0;
        end else begin
            bus.F_mem_valid   <= 1'b0;
            bus.MEM_mem_valid <= 1'b0;
            bus.Dc_wb_done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state       <= ST_BUSY;
                        gnt         <= gnt_sel;
                        bus.Mem_req <= 1'b1;
                        case (gnt_sel)
                            G_WB: begin
                                bus.Mem_we    <= 1'b1;
                                bus.Mem_addr  <= bus.Dc_wb_addr;
                                bus.Mem_wline <= bus.Dc_wb_wline;
                            end
                            G_DRD: begin
                                bus.Mem_we    <= 1'b0;
                                bus.Mem_addr  <= bus.Dc_mem_addr;
                                bus.Mem_wline <= '0;
                            end
                            default: begin
                                bus.Mem_we    <= 1'b0;
                                bus.Mem_addr  <= bus.Ic_mem_addr;
                                bus.Mem_wline <= '0;
                            end
                        endcase
                        if (bus.Ic_mem_req && (gnt_sel != G_I)) begin
                            if (d_streak != STREAK_MAX) begin
                                d_streak <= d_streak + 1'b1;
                            end
                        end else begin
                            d_streak <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.Mem_done) begin
                        state       <= ST_RESP;
                        bus.Mem_req <= 1'b0;
                        case (gnt)
                            G_WB: begin
                                bus.Dc_wb_done <= 1'b1;
                            end
                            G_DRD: begin
                                bus.MEM_data_line <= bus.Mem_rline;
                                bus.MEM_mem_valid <= 1'b1;
                            end
                            default: begin
                                bus.F_mem_inst  <= bus.Mem_rline;
                                bus.F_mem_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: a memory responder model, a response
// scoreboard filled at stimulus time, and a linear sequence of scenarios.
module tb_line_mem_arbiter;
    localparam int LW = 128;
    localparam int AW = 10;

    typedef struct packed {
        logic [1:0]    kind;
        logic [LW-1:0] data;
    } resp_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wline;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_mem_arbiter_if #(.LINE_W(LW), .LADDR_W(AW)) bus ();

    line_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    resp_t         exp_q[$];
    op_t           op_q[$];
    logic [LW-1:0] mem_line [1024];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            resp_cnt = 0;
    int            last_pulse_cyc = 0;
    int            mem_lat = 1;
    bit            inject_stray = 1'b0;

    localparam logic [LW-1:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LW-1:0] D1 = {4{32'h5A5A_F00D}};

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_pat(input int a);
        logic [9:0] a10;
        a10 = a[9:0];
        return {4{16'hBEEF, 6'd0, a10}};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_resp(input int n, input string tag);
        for (int i = 0; i < 200 && resp_cnt < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, LW'(resp_cnt >= n), LW'(1));
    endtask

    task automatic wait_memreq(input string tag);
        for (int i = 0; i < 50 && !bus.Mem_req; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, LW'(bus.Mem_req), LW'(1));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        int         np;
        resp_t      e;
        logic [1:0] k;
        if (rst) begin
            np = int'(bus.F_mem_valid) + int'(bus.MEM_mem_valid) + int'(bus.Dc_wb_done);
            if (np != 0) begin
                chk("pulse_onehot", LW'(np), LW'(1));
                chk("resp_expected", LW'(exp_q.size() > 0), LW'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    k = bus.Dc_wb_done ? 2'd2 : (bus.MEM_mem_valid ? 2'd1 : 2'd0);
                    chk("resp_kind", LW'(k), LW'(e.kind));
                    if (k == 2'd0) chk("f_mem_inst", bus.F_mem_inst, e.data);
                    if (k == 2'd1) chk("mem_data_line", bus.MEM_data_line, e.data);
                end
                last_pulse_cyc = cyc;
                resp_cnt++;
            end
        end
    end

    // Backing memory: completes each request after mem_lat cycles of Mem_req.
    initial begin
        int  cnt;
        op_t o;
        cnt = 0;
        bus.Mem_done  = 1'b0;
        bus.Mem_rline = '0;
        forever begin
            @(negedge clk);
            bus.Mem_done = 1'b0;
            if (!rst) begin
                cnt = 0;
            end else if (bus.Mem_req) begin
                cnt++;
                if (cnt == 1) begin
                    chk("op_expected", LW'(op_q.size() > 0), LW'(1));
                    if (op_q.size() > 0) begin
                        o = op_q.pop_front();
                        chk("mem_we", LW'(bus.Mem_we), LW'(o.we));
                        chk("mem_addr", LW'(bus.Mem_addr), LW'(o.addr));
                        if (o.we) chk("mem_wline", bus.Mem_wline, o.wline);
                    end
                end
                if (cnt >= mem_lat) begin
                    bus.Mem_done = 1'b1;
                    if (bus.Mem_we) mem_line[bus.Mem_addr] = bus.Mem_wline;
                    else bus.Mem_rline = mem_line[bus.Mem_addr];
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (inject_stray) begin
                    bus.Mem_done = 1'b1;
                    inject_stray = 1'b0;
                end
            end
        end
    end

    initial begin
        int  n0;
        int  c0;
        int  p1;
        int  ia;
        int  da;
        bit  is_i [10];

        bus.Ic_mem_req  = 1'b0;
        bus.Ic_mem_addr = '0;
        bus.Dc_mem_req  = 1'b0;
        bus.Dc_mem_addr = '0;
        bus.Dc_wb_we    = 1'b0;
        bus.Dc_wb_addr  = '0;
        bus.Dc_wb_wline = '0;
        for (int i = 0; i < 1024; i++) mem_line[i] = line_pat(i);
        mem_line[10'h012] = {16{8'hA5}};

        // Reset state
        rst = 1'b0;
        step(3);
        chk("rst_mem_req", LW'(bus.Mem_req), LW'(0));
        chk("rst_mem_we", LW'(bus.Mem_we), LW'(0));
        chk("rst_mem_addr", LW'(bus.Mem_addr), LW'(0));
        chk("rst_mem_wline", bus.Mem_wline, '0);
        chk("rst_f_valid", LW'(bus.F_mem_valid), LW'(0));
        chk("rst_f_inst", bus.F_mem_inst, '0);
        chk("rst_d_valid", LW'(bus.MEM_mem_valid), LW'(0));
        chk("rst_d_line", bus.MEM_data_line, '0);
        chk("rst_wb_done", LW'(bus.Dc_wb_done), LW'(0));
        rst = 1'b1;
        step(2);

        // Reset in the middle of a transaction
        mem_lat = 5;
        op_q.push_back('{we: 1'b0, addr: 10'h005, wline: '0});
        bus.Ic_mem_addr = 10'h005;
        bus.Ic_mem_req  = 1'b1;
        wait_memreq("abort_req_seen");
        step(2);
        rst = 1'b0;
        #1;
        chk("abort_mem_req", LW'(bus.Mem_req), LW'(0));
        bus.Ic_mem_req = 1'b0;
        step(2);
        rst = 1'b1;
        n0 = resp_cnt;
        step(6);
        chk("abort_no_pulse", LW'(resp_cnt), LW'(n0));
        chk("abort_idle", LW'(bus.Mem_req), LW'(0));

        // Single I fill, k=3
        mem_lat = 3;
        op_q.push_back('{we: 1'b0, addr: 10'h012, wline: '0});
        exp_q.push_back('{kind: 2'd0, data: {16{8'hA5}}});
        bus.Ic_mem_addr = 10'h012;
        bus.Ic_mem_req  = 1'b1;
        c0 = cyc;
        n0 = resp_cnt;
        wait_resp(n0 + 1, "ifill_resp");
        bus.Ic_mem_req = 1'b0;
        chk("ifill_latency", LW'(last_pulse_cyc - c0), LW'(4));
        step(2);
        chk("ifill_single_pulse", LW'(resp_cnt), LW'(n0 + 1));
        chk("ifill_hold", bus.F_mem_inst, {16{8'hA5}});

        // Eviction: WB and DRD together, WB first
        mem_lat = 2;
        op_q.push_back('{we: 1'b1, addr: 10'h040, wline: D0});
        op_q.push_back('{we: 1'b0, addr: 10'h080, wline: '0});
        exp_q.push_back('{kind: 2'd2, data: '0});
        exp_q.push_back('{kind: 2'd1, data: line_pat(10'h080)});
        bus.Dc_wb_addr  = 10'h040;
        bus.Dc_wb_wline = D0;
        bus.Dc_wb_we    = 1'b1;
        bus.Dc_mem_addr = 10'h080;
        bus.Dc_mem_req  = 1'b1;
        n0 = resp_cnt;
        wait_resp(n0 + 1, "evict_wb_resp");
        bus.Dc_wb_we = 1'b0;
        wait_resp(n0 + 2, "evict_rd_resp");
        bus.Dc_mem_req = 1'b0;
        chk("evict_written", mem_line[10'h040], D0);
        step(2);

        // Contention: four D grants, then I; the I grant clears the streak
        mem_lat = 1;
        is_i = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        ia = 0;
        da = 0;
        for (int j = 0; j < 10; j++) begin
            if (is_i[j]) begin
                op_q.push_back('{we: 1'b0, addr: AW'(10'h0A0 + ia), wline: '0});
                exp_q.push_back('{kind: 2'd0, data: line_pat(10'h0A0 + ia)});
                ia++;
            end else begin
                op_q.push_back('{we: 1'b0, addr: AW'(10'h100 + da), wline: '0});
                exp_q.push_back('{kind: 2'd1, data: line_pat(10'h100 + da)});
                da++;
            end
        end
        ia = 0;
        da = 0;
        bus.Ic_mem_addr = 10'h0A0;
        bus.Ic_mem_req  = 1'b1;
        bus.Dc_mem_addr = 10'h100;
        bus.Dc_mem_req  = 1'b1;
        n0 = resp_cnt;
        for (int j = 0; j < 10; j++) begin
            wait_resp(n0 + j + 1, "contend_resp");
            if (is_i[j]) begin
                ia++;
                bus.Ic_mem_addr = AW'(10'h0A0 + ia);
            end else begin
                da++;
                bus.Dc_mem_addr = AW'(10'h100 + da);
            end
        end
        bus.Ic_mem_req = 1'b0;
        bus.Dc_mem_req = 1'b0;
        step(3);

        // Stall with stable command while the granted request drops
        mem_lat = 11;
        op_q.push_back('{we: 1'b1, addr: 10'h3C5, wline: D1});
        exp_q.push_back('{kind: 2'd2, data: '0});
        bus.Dc_wb_addr  = 10'h3C5;
        bus.Dc_wb_wline = D1;
        bus.Dc_wb_we    = 1'b1;
        n0 = resp_cnt;
        wait_memreq("stall_req_seen");
        bus.Dc_wb_we    = 1'b0;
        bus.Dc_wb_addr  = 10'h111;
        bus.Dc_wb_wline = ~D1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_mem_req", LW'(bus.Mem_req), LW'(1));
            chk("stall_mem_addr", LW'(bus.Mem_addr), LW'(10'h3C5));
            chk("stall_mem_we", LW'(bus.Mem_we), LW'(1));
            chk("stall_mem_wline", bus.Mem_wline, D1);
            step(1);
        end
        wait_resp(n0 + 1, "stall_resp");
        step(3);
        chk("stall_one_pulse", LW'(resp_cnt), LW'(n0 + 1));
        inject_stray = 1'b1;
        step(4);
        chk("stray_no_pulse", LW'(resp_cnt), LW'(n0 + 1));
        chk("stray_no_req", LW'(bus.Mem_req), LW'(0));

        // Back-to-back I fills
        mem_lat = 1;
        op_q.push_back('{we: 1'b0, addr: 10'h001, wline: '0});
        op_q.push_back('{we: 1'b0, addr: 10'h002, wline: '0});
        exp_q.push_back('{kind: 2'd0, data: mem_line[10'h001]});
        exp_q.push_back('{kind: 2'd0, data: mem_line[10'h002]});
        bus.Ic_mem_addr = 10'h001;
        bus.Ic_mem_req  = 1'b1;
        n0 = resp_cnt;
        wait_resp(n0 + 1, "b2b_first");
        p1 = last_pulse_cyc;
        bus.Ic_mem_addr = 10'h002;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.F_mem_valid) break;
            chk("b2b_hold_first", bus.F_mem_inst, mem_line[10'h001]);
        end
        wait_resp(n0 + 2, "b2b_second");
        bus.Ic_mem_req = 1'b0;
        chk("b2b_gap", LW'(last_pulse_cyc - p1), LW'(3));
        step(3);

        chk("sb_drained", LW'(exp_q.size()), LW'(0));
        chk("ops_drained", LW'(op_q.size()), LW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
